// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter and its clients.
package dmem_arb_pkg;
  localparam int DMEM_ADDR_W = 12;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_CPU_RD = 2'd1,
    OWN_VGA_RD = 2'd2
  } owner_e;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU / VGA requesters, the arbiter and the dmem macro.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  logic [ADDR_W-1:0] dmem_address;
  logic [DATA_W-1:0] dmem_data_in;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_q,
    output cpu_gnt, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata,
           mem_address, mem_data, mem_wren, dmem_address, dmem_data_in
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_q,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata,
           mem_address, mem_data, mem_wren, dmem_address, dmem_data_in
  );
endinterface

// File: rtl/dmem_arb_starve_ctr.sv
// VGA wait counter: counts consecutive denied VGA cycles and raises force_vga
// once MAX_WAIT is reached. Used only when DMEM_ARB_STARVE_GUARD_EN is defined.
module dmem_arb_starve_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic vga_req,
  input  logic vga_gnt,
  output logic force_vga
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (vga_gnt || !vga_req) begin
      wait_cnt <= '0;
    end else if (wait_cnt != MAX_CNT) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign force_vga = (wait_cnt == MAX_CNT);
endmodule

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter: CPU load/store vs VGA read, one grant per cycle.
// Optional VGA starvation guard enabled by defining DMEM_ARB_STARVE_GUARD_EN.
//
//  state      | meaning
//  OWN_NONE   | no read returns this cycle
//  OWN_CPU_RD | mem_q carries the CPU load issued last edge
//  OWN_VGA_RD | mem_q carries the VGA read issued last edge
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input logic          clock,
  input logic          reset,
  dmem_arbiter_if.slave bus
);
  owner_e            owner_q, owner_d;
  logic              cpu_gnt, vga_gnt, force_vga;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] data_mux;
  logic              wren_mux;
  logic [DATA_W-1:0] cpu_hold_q, vga_hold_q;

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("dmem_arbiter: MAX_WAIT must be >= 1");
  end

`ifdef DMEM_ARB_STARVE_GUARD_EN
  dmem_arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve_ctr (
    .clock     (clock),
    .reset     (reset),
    .vga_req   (bus.vga_req),
    .vga_gnt   (vga_gnt),
    .force_vga (force_vga)
  );
`else
  assign force_vga = 1'b0;
`endif

  // force_vga comes from a register, so there is no loop through vga_gnt.
  always_comb begin
    cpu_gnt = 1'b0;
    vga_gnt = 1'b0;
    if (reset) begin
      if (bus.vga_req && (force_vga || !bus.cpu_req)) vga_gnt = 1'b1;
      else if (bus.cpu_req)                             cpu_gnt = 1'b1;
    end
  end

  always_comb begin
    addr_mux = '0;
    data_mux = '0;
    wren_mux = 1'b0;
    if (cpu_gnt) begin
      addr_mux = bus.cpu_addr;
      data_mux = bus.cpu_wdata;
      wren_mux = bus.cpu_we;
    end else if (vga_gnt) begin
      addr_mux = bus.vga_addr;
    end
  end

  assign bus.cpu_gnt      = cpu_gnt;
  assign bus.vga_gnt      = vga_gnt;
  assign bus.mem_address  = addr_mux;
  assign bus.mem_data     = data_mux;
  assign bus.mem_wren     = wren_mux;
  assign bus.dmem_address = addr_mux;
  assign bus.dmem_data_in = data_mux;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) owner_q <= OWN_NONE;
    else        owner_q <= owner_d;
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (cpu_gnt && !bus.cpu_we) owner_d = OWN_CPU_RD;
    else if (vga_gnt)           owner_d = OWN_VGA_RD;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cpu_hold_q <= '0;
      vga_hold_q <= '0;
    end else begin
      if (owner_q == OWN_CPU_RD) cpu_hold_q <= bus.mem_q;
      if (owner_q == OWN_VGA_RD) vga_hold_q <= bus.mem_q;
    end
  end

  assign bus.cpu_rvalid = (owner_q == OWN_CPU_RD);
  assign bus.vga_rvalid = (owner_q == OWN_VGA_RD);
  assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_q : cpu_hold_q;
  assign bus.vga_rdata  = bus.vga_rvalid ? bus.mem_q : vga_hold_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model of the arbiter.
module tb_dmem_arbiter;
  localparam int MAX_WAIT = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] init_val(input logic [11:0] a);
    case (a)
      12'h005: return 32'hDEADBEEF;
      12'h020: return 32'hA0A0A0A0;
      12'h021: return 32'hB1B1B1B1;
      12'h022: return 32'hC2C2C2C2;
      default: return ({20'd0, a} * 32'h9E3779B1) ^ 32'h5A5A0000;
    endcase
  endfunction

  // Memory macro emulation: synchronous write, registered read.
  logic [31:0] dmem [0:4095];
  bit          dmem_wr [0:4095];
  always @(posedge clock) begin
    if (bus.mem_wren) begin
      dmem[bus.mem_address]    <= bus.mem_data;
      dmem_wr[bus.mem_address] <= 1'b1;
    end
    bus.mem_q <= dmem_wr[bus.mem_address] ? dmem[bus.mem_address]
                                          : init_val(bus.mem_address);
  end

  // Reference model state
  logic [31:0] ref_mem [0:4095];
  bit          ref_wr [0:4095];
  bit          m_cpu_rv, m_vga_rv;
  logic [31:0] m_cpu_next, m_vga_next, m_cpu_hold, m_vga_hold;
  int          m_wait;
  bit          last_cg, last_vg;

  function automatic logic [31:0] ref_val(input logic [11:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    bit          e_cg, e_vg, e_we, force_v;
    logic [11:0] e_addr;
    logic [31:0] e_data;
    if (!reset) begin
      m_cpu_rv = 0; m_vga_rv = 0; m_cpu_hold = '0; m_vga_hold = '0; m_wait = 0;
    end
    force_v = 0;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    force_v = (m_wait == MAX_WAIT);
`endif
    e_vg   = reset && bus.vga_req && (!bus.cpu_req || force_v);
    e_cg   = reset && bus.cpu_req && !e_vg;
    e_addr = e_cg ? bus.cpu_addr : (e_vg ? bus.vga_addr : 12'h000);
    e_data = e_cg ? bus.cpu_wdata : 32'h0;
    e_we   = e_cg && bus.cpu_we;

    chk("cpu_gnt",      {31'd0, bus.cpu_gnt},    {31'd0, e_cg});
    chk("vga_gnt",      {31'd0, bus.vga_gnt},    {31'd0, e_vg});
    chk("mem_address",  {20'd0, bus.mem_address}, {20'd0, e_addr});
    chk("mem_data",     bus.mem_data,            e_data);
    chk("mem_wren",     {31'd0, bus.mem_wren},   {31'd0, e_we});
    chk("dmem_address", {20'd0, bus.dmem_address}, {20'd0, e_addr});
    chk("dmem_data_in", bus.dmem_data_in,        e_data);
    chk("cpu_rvalid",   {31'd0, bus.cpu_rvalid}, {31'd0, m_cpu_rv});
    chk("vga_rvalid",   {31'd0, bus.vga_rvalid}, {31'd0, m_vga_rv});
    chk("cpu_rdata",    bus.cpu_rdata, m_cpu_rv ? m_cpu_next : m_cpu_hold);
    chk("vga_rdata",    bus.vga_rdata, m_vga_rv ? m_vga_next : m_vga_hold);

    last_cg = bus.cpu_gnt;
    last_vg = bus.vga_gnt;

    if (m_cpu_rv) m_cpu_hold = m_cpu_next;
    if (m_vga_rv) m_vga_hold = m_vga_next;
    m_cpu_rv   = e_cg && !bus.cpu_we;
    m_cpu_next = ref_val(bus.cpu_addr);
    m_vga_rv   = e_vg;
    m_vga_next = ref_val(bus.vga_addr);
    if (e_we) begin
      ref_mem[bus.cpu_addr] = bus.cpu_wdata;
      ref_wr[bus.cpu_addr]  = 1'b1;
    end
    if (e_vg || !bus.vga_req) m_wait = 0;
    else if (m_wait < MAX_WAIT) m_wait++;
  endtask

  task automatic step(input bit rst, input bit cr, input bit cw, input logic [11:0] ca,
                      input logic [31:0] cd, input bit vr, input logic [11:0] va);
    @(posedge clock);
    #1;
    reset         = rst;
    bus.cpu_req   = cr;
    bus.cpu_we    = cw;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cd;
    bus.vga_req   = vr;
    bus.vga_addr  = va;
    @(negedge clock);
    model_check();
  endtask

  initial begin
    int n_cg, n_vg;
    bit c_req, c_we, v_req, rst;
    logic [11:0] c_addr, v_addr;
    logic [31:0] c_data;

    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.vga_req = 0; bus.vga_addr = '0;
    for (int i = 0; i < 4096; i++) begin
      ref_mem[i] = '0;
      ref_wr[i]  = 1'b0;
    end
    m_cpu_rv = 0; m_vga_rv = 0; m_cpu_hold = '0; m_vga_hold = '0;
    m_cpu_next = '0; m_vga_next = '0; m_wait = 0;

    // Reset state, with requests active to confirm grants are suppressed
    step(0, 1, 0, 12'h001, 32'h0, 1, 12'h002);
    chk("rst_cpu_gnt",   {31'd0, bus.cpu_gnt}, 32'd0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
    chk("rst_vga_rdata", bus.vga_rdata, 32'h0);

    // CPU load of 0x005
    step(1, 1, 0, 12'h005, 32'h0, 0, 12'h000);
    chk("ld_cpu_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
    chk("ld_mem_address", {20'd0, bus.mem_address}, 32'h005);
    step(1, 0, 0, 12'h000, 32'h0, 0, 12'h000);
    chk("ld_cpu_rvalid", {31'd0, bus.cpu_rvalid}, 32'd1);
    chk("ld_cpu_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    step(1, 0, 0, 12'h000, 32'h0, 0, 12'h000);
    chk("ld_hold_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);
    chk("ld_hold_rdata", bus.cpu_rdata, 32'hDEADBEEF);

    // Store then VGA read of the same word
    step(1, 1, 1, 12'h010, 32'h12345678, 0, 12'h000);
    chk("st_mem_wren", {31'd0, bus.mem_wren}, 32'd1);
    chk("st_dmem_address", {20'd0, bus.dmem_address}, 32'h010);
    chk("st_dmem_data_in", bus.dmem_data_in, 32'h12345678);
    step(1, 0, 0, 12'h000, 32'h0, 1, 12'h010);
    chk("vr_vga_gnt", {31'd0, bus.vga_gnt}, 32'd1);
    chk("vr_mem_wren", {31'd0, bus.mem_wren}, 32'd0);
    step(1, 0, 0, 12'h000, 32'h0, 0, 12'h000);
    chk("vr_vga_rvalid", {31'd0, bus.vga_rvalid}, 32'd1);
    chk("vr_vga_rdata", bus.vga_rdata, 32'h12345678);

    // Back-to-back CPU, VGA, CPU loads
    step(1, 1, 0, 12'h020, 32'h0, 0, 12'h000);
    step(1, 0, 0, 12'h000, 32'h0, 1, 12'h021);
    chk("b2b_cpu_rdata", bus.cpu_rdata, 32'hA0A0A0A0);
    step(1, 1, 0, 12'h022, 32'h0, 0, 12'h000);
    chk("b2b_vga_rvalid", {31'd0, bus.vga_rvalid}, 32'd1);
    chk("b2b_vga_rdata", bus.vga_rdata, 32'hB1B1B1B1);
    chk("b2b_cpu_rvalid0", {31'd0, bus.cpu_rvalid}, 32'd0);
    step(1, 0, 0, 12'h000, 32'h0, 0, 12'h000);
    chk("b2b_cpu_rdata2", bus.cpu_rdata, 32'hC2C2C2C2);

    // Contention: both requesters held for six cycles
    n_cg = 0; n_vg = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0, 12'h001, 32'h0, 1, 12'h002);
      n_cg += int'(bus.cpu_gnt);
      n_vg += int'(bus.vga_gnt);
    end
`ifdef DMEM_ARB_STARVE_GUARD_EN
    chk("cont_cpu_gnts", n_cg, 32'd5);
    chk("cont_vga_gnts", n_vg, 32'd1);
`else
    chk("cont_cpu_gnts", n_cg, 32'd6);
    chk("cont_vga_gnts", n_vg, 32'd0);
`endif

    // Reset pulsed the cycle after a VGA grant
    step(1, 0, 0, 12'h000, 32'h0, 1, 12'h003);
    step(0, 0, 0, 12'h000, 32'h0, 0, 12'h000);
    chk("rmid_vga_rvalid", {31'd0, bus.vga_rvalid}, 32'd0);
    step(1, 0, 0, 12'h000, 32'h0, 0, 12'h000);
    chk("rrel_vga_rvalid", {31'd0, bus.vga_rvalid}, 32'd0);
    chk("rrel_vga_rdata", bus.vga_rdata, 32'h0);
    step(1, 1, 0, 12'h004, 32'h0, 0, 12'h000);
    chk("rrel_cpu_gnt", {31'd0, bus.cpu_gnt}, 32'd1);

    // Randomized traffic honouring the hold-until-grant handshake
    c_req = 0; c_we = 0; c_addr = '0; c_data = '0; v_req = 0; v_addr = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!c_req || last_cg) begin
        c_req  = ($urandom_range(0, 3) != 0);
        c_we   = ($urandom_range(0, 2) == 0);
        c_addr = 12'($urandom_range(0, 15));
        c_data = $urandom;
      end
      if (!v_req || last_vg) begin
        v_req  = ($urandom_range(0, 2) != 0);
        v_addr = 12'($urandom_range(0, 15));
      end
      rst = ($urandom_range(0, 299) != 0);
      step(rst, c_req, c_we, c_addr, c_data, v_req, v_addr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
